// File: rtl/sparce_skip_unit.sv
// sparce_skip_unit: zero-register tracker plus programmable skip table that redirects fetch past skippable blocks
module sparce_skip_unit #(
  parameter int SASA_ENTRIES = 16,
  parameter logic [31:0] SASA_BASE = 32'h9000_0000,
  parameter int HOLDOFF = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  input  logic [31:0] rdata,
  input  logic        if_ex_enable,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  output logic        skipping,
  output logic [31:0] sparce_target
);
  localparam int LG = $clog2(SASA_ENTRIES);
  localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [31:0] SPAN = 32'(8 * SASA_ENTRIES);
  logic [31:0] z, zb, off;
  logic [31:0] tag [SASA_ENTRIES];
  logic [1:0]  mode [SASA_ENTRIES];
  logic [4:0]  rs1 [SASA_ENTRIES];
  logic [4:0]  rs2 [SASA_ENTRIES];
  logic [11:0] cnt [SASA_ENTRIES];
  logic [SASA_ENTRIES-1:0] vld;
  logic [HW-1:0] hold;
  logic [LG-1:0] idx;
  logic [11:0] hit_n;
  logic in_win, hit, fire, unused_ok;
  function automatic logic cond_ok(input logic [1:0] m, input logic a, input logic b);
    return m == 2'd0 ? a : m == 2'd1 ? a & b : m == 2'd2 ? a | b : 1'b0;
  endfunction
  assign off = sasa_addr - SASA_BASE;
  assign in_win = sasa_wen && off < SPAN && sasa_addr[1:0] == 2'b00;
  assign idx = off[LG+2:3];
  assign fire = hit && if_ex_enable && hold == '0;
  assign unused_ok = ^{rdata, off[31:LG+3], off[1:0]};
  always_comb begin
    zb = z;
    if (wb_en && rd != 5'd0) zb[rd] = wb_data == 32'd0;
  end
  // descending scan so the lowest matching index is the last to claim the hit
  always_comb begin
    hit = 1'b0;
    hit_n = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--)
      if (vld[i] && cnt[i] != '0 && tag[i] == pc && cond_ok(mode[i], zb[rs1[i]], zb[rs2[i]])) begin
        hit = 1'b1;
        hit_n = cnt[i];
      end
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      z <= '1;
      vld <= '0;
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        tag[i] <= '0;
        mode[i] <= '0;
        rs1[i] <= '0;
        rs2[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (wb_en && rd != 5'd0) z[rd] <= wb_data == 32'd0;
      if (in_win && !off[2]) tag[idx] <= sasa_data;
      if (in_win && off[2]) begin
        vld[idx] <= sasa_data[31];
        mode[idx] <= sasa_data[30:29];
        rs2[idx] <= sasa_data[24:20];
        rs1[idx] <= sasa_data[19:15];
        cnt[idx] <= sasa_data[11:0];
      end
    end
  // holdoff is loaded on the same edge that raises skipping
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      skipping <= 1'b0;
      sparce_target <= '0;
      hold <= '0;
    end else begin
      skipping <= fire;
      if (fire) sparce_target <= pc + {18'd0, hit_n, 2'b00};
      hold <= fire ? HW'(HOLDOFF) : hold != '0 ? hold - 1'b1 : hold;
    end
endmodule
